// File: rtl/mc_datapath_p_if.sv
`default_nettype none
// ============================================================================
// Interface : mc_datapath_p_if
// Brief     : Controller selects, decoded instruction fields and the external
//             memory handshake of the multi-cycle datapath.
//             master = controller / memory side, slave = datapath.
// Revision  : 1.0 - initial release
// ============================================================================
interface mc_datapath_p_if #(
    parameter int WIDTH = 32
);
    // Single-bit controller strobes and selects
    logic             mem_to_reg;
    logic             reg_dest;
    logic             i_or_d;
    logic             alu_src_a;
    logic             ir_write;
    logic             mem_read;
    logic             mem_write;
    logic             pc_write;
    logic             branch;
    logic             branch_ne;
    logic             reg_write;
    // Multi-bit controller selects
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_src;
    logic [2:0]       alu_control;
    // Status back to the controller
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_wait;
    // External memory handshake
    logic             mem_req;
    logic             mem_we;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic [WIDTH-1:0] mem_rdata;
    logic             mem_ready;

    modport master (
        output mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_read,
               mem_write, pc_write, branch, branch_ne, reg_write,
               alu_src_b, pc_src, alu_control, mem_rdata, mem_ready,
        input  opcode, funct, zero, mem_wait, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_read,
               mem_write, pc_write, branch, branch_ne, reg_write,
               alu_src_b, pc_src, alu_control, mem_rdata, mem_ready,
        output opcode, funct, zero, mem_wait, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/mc_datapath_p.sv
`default_nettype none
// ============================================================================
// Module   : mc_datapath_p
// Brief    : Multi-cycle MIPS-style datapath (PC, IR, MDR, A, B, ALUOut,
//            register file, ALU) with a stalling memory handshake.
// Options  : define MC_DP_PERF_EN to add cycle_count / retire_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module mc_datapath_p #(
    parameter int               WIDTH    = 32,
    parameter int               NREGS    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MC_DP_PERF_EN
    output logic [31:0] cycle_count,
    output logic [31:0] retire_count,
`endif
    mc_datapath_p_if.slave bus
);

    localparam int               c_AW      = $clog2(NREGS);
    localparam logic [WIDTH-1:0] c_FOUR    = WIDTH'(4);
    localparam logic [2:0]       c_ALU_AND = 3'b000;
    localparam logic [2:0]       c_ALU_OR  = 3'b001;
    localparam logic [2:0]       c_ALU_ADD = 3'b010;
    localparam logic [2:0]       c_ALU_SUB = 3'b110;
    localparam logic [2:0]       c_ALU_SLT = 3'b111;

    logic [WIDTH-1:0] r_pc;
    logic [31:0]      r_ir;
    logic [WIDTH-1:0] r_mdr;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_aluout;
    logic [WIDTH-1:0] r_rf [NREGS];

    logic             w_req;
    logic             w_stall;
    logic [c_AW-1:0]  w_ra;
    logic [c_AW-1:0]  w_rb;
    logic [c_AW-1:0]  w_wa;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [WIDTH-1:0] w_wr_data;
    logic             w_rf_we;
    logic [WIDTH-1:0] w_sext;
    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_src_b;
    logic [WIDTH-1:0] w_alu;
    logic             w_zero;
    logic             w_pc_en;
    logic [WIDTH-1:0] w_pc_next;

    // Memory handshake: a request is never raised while reset is asserted
    assign w_req         = rst_n & (bus.ir_write | bus.mem_read | bus.mem_write);
    assign w_stall       = w_req & ~bus.mem_ready;
    assign bus.mem_req   = w_req;
    assign bus.mem_wait  = w_stall;
    assign bus.mem_we    = bus.mem_write;
    assign bus.mem_addr  = bus.i_or_d ? r_aluout : r_pc;
    assign bus.mem_wdata = r_b;
    assign bus.opcode    = r_ir[31:26];
    assign bus.funct     = r_ir[5:0];
    assign bus.zero      = w_zero;

    // Register file indices truncated to the implemented depth; r0 is hardwired to zero
    assign w_ra      = r_ir[21 +: c_AW];
    assign w_rb      = r_ir[16 +: c_AW];
    assign w_wa      = bus.reg_dest ? r_ir[11 +: c_AW] : r_ir[16 +: c_AW];
    assign w_rd_a    = (w_ra == '0) ? '0 : r_rf[w_ra];
    assign w_rd_b    = (w_rb == '0) ? '0 : r_rf[w_rb];
    assign w_wr_data = bus.mem_to_reg ? r_mdr : r_aluout;
    assign w_rf_we   = bus.reg_write & ~w_stall & (w_wa != '0);

    assign w_sext  = {{(WIDTH-16){r_ir[15]}}, r_ir[15:0]};
    assign w_src_a = bus.alu_src_a ? r_a : r_pc;

    // ALU operand B select
    always_comb begin
        w_src_b = r_b;
        case (bus.alu_src_b)
            2'b00:   w_src_b = r_b;
            2'b01:   w_src_b = c_FOUR;
            2'b10:   w_src_b = w_sext;
            default: w_src_b = {w_sext[WIDTH-3:0], 2'b00};
        endcase
    end

    // ALU; unlisted control codes produce zero
    always_comb begin
        w_alu = '0;
        case (bus.alu_control)
            c_ALU_ADD: w_alu = w_src_a + w_src_b;
            c_ALU_SUB: w_alu = w_src_a - w_src_b;
            c_ALU_AND: w_alu = w_src_a & w_src_b;
            c_ALU_OR:  w_alu = w_src_a | w_src_b;
            c_ALU_SLT: w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_src_a) < $signed(w_src_b))};
            default:   w_alu = '0;
        endcase
    end

    assign w_zero  = (w_alu == '0);
    assign w_pc_en = ~w_stall & (bus.pc_write | (bus.branch & w_zero) | (bus.branch_ne & ~w_zero));

    // Next-PC source select
    always_comb begin
        w_pc_next = w_alu;
        case (bus.pc_src)
            2'b00:   w_pc_next = w_alu;
            2'b01:   w_pc_next = r_aluout;
            2'b10:   w_pc_next = {r_pc[WIDTH-1:28], r_ir[25:0], 2'b00};
            default: w_pc_next = r_a;
        endcase
    end

    // Architectural registers; everything freezes while a transfer is outstanding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc     <= RESET_PC;
            r_ir     <= '0;
            r_mdr    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_aluout <= '0;
        end else if (!w_stall) begin
            r_a      <= w_rd_a;
            r_b      <= w_rd_b;
            r_aluout <= w_alu;
            if (bus.ir_write && bus.mem_ready) begin
                r_ir <= bus.mem_rdata[31:0];
            end
            if (bus.mem_read && bus.mem_ready) begin
                r_mdr <= bus.mem_rdata;
            end
            if (w_pc_en) begin
                r_pc <= w_pc_next;
            end
        end
    end

    // Register file write port; reads are asynchronous with no write forwarding
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                r_rf[i] <= '0;
            end
        end else if (w_rf_we) begin
            r_rf[w_wa] <= w_wr_data;
        end
    end

`ifdef MC_DP_PERF_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_retire_cnt;

    // Free-running cycle counter and completed-fetch counter, both wrap naturally
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else begin
            r_cycle_cnt <= r_cycle_cnt + 32'd1;
            if (bus.ir_write && bus.mem_ready) begin
                r_retire_cnt <= r_retire_cnt + 32'd1;
            end
        end
    end

    assign cycle_count  = r_cycle_cnt;
    assign retire_count = r_retire_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc_datapath_p
// Brief    : Self-checking bench for mc_datapath_p: behavioural reference model
//            compared on every cycle, directed scenarios with literal values,
//            then randomized control/memory stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc_datapath_p;

    localparam int            W   = 32;
    localparam int            NR  = 16;
    localparam logic [W-1:0]  RPC = 32'h100;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_en = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mc_datapath_p_if #(.WIDTH(W)) bus ();

`ifdef MC_DP_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] retire_count;
`endif

    mc_datapath_p #(
        .WIDTH    (W),
        .NREGS    (NR),
        .RESET_PC (RPC)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
`ifdef MC_DP_PERF_EN
        .cycle_count  (cycle_count),
        .retire_count (retire_count),
`endif
        .bus          (bus)
    );

    // ---------------- behavioural model state ----------------
    logic [W-1:0] m_pc, m_mdr, m_a, m_b, m_alo;
    logic [31:0]  m_ir;
    logic [W-1:0] m_rf [NR];
    logic [31:0]  m_cyc, m_ret;

    function automatic logic [W-1:0] f_alu();
        logic [W-1:0] a, b, imm;
        imm = {{(W-16){m_ir[15]}}, m_ir[15:0]};
        a = bus.alu_src_a ? m_a : m_pc;
        case (bus.alu_src_b)
            2'd0:    b = m_b;
            2'd1:    b = W'(4);
            2'd2:    b = imm;
            default: b = imm * 4;
        endcase
        case (bus.alu_control)
            3'b010:  return a + b;
            3'b110:  return a - b;
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: return W'(0);
        endcase
    endfunction

    function automatic logic f_req();
        return rst_n & (bus.ir_write | bus.mem_read | bus.mem_write);
    endfunction

    function automatic logic f_wait();
        return f_req() & ~bus.mem_ready;
    endfunction

    function automatic int f_wdst();
        return (bus.reg_dest ? int'(m_ir[15:11]) : int'(m_ir[20:16])) % NR;
    endfunction

    function automatic logic f_pc_take();
        logic z;
        z = (f_alu() == '0);
        return bus.pc_write | (bus.branch & z) | (bus.branch_ne & ~z);
    endfunction

    function automatic logic [W-1:0] f_pc_next();
        case (bus.pc_src)
            2'd0:    return f_alu();
            2'd1:    return m_alo;
            2'd2:    return {m_pc[W-1:28], m_ir[25:0], 2'b00};
            default: return m_a;
        endcase
    endfunction

    // Model state update at each rising edge
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pc  <= RPC;
            m_ir  <= '0;
            m_mdr <= '0;
            m_a   <= '0;
            m_b   <= '0;
            m_alo <= '0;
            m_cyc <= '0;
            m_ret <= '0;
            for (int i = 0; i < NR; i++) m_rf[i] <= '0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (bus.ir_write && bus.mem_ready) m_ret <= m_ret + 1;
            if (!f_wait()) begin
                m_a   <= m_rf[int'(m_ir[25:21]) % NR];
                m_b   <= m_rf[int'(m_ir[20:16]) % NR];
                m_alo <= f_alu();
                if (bus.ir_write && bus.mem_ready) m_ir <= bus.mem_rdata[31:0];
                if (bus.mem_read && bus.mem_ready) m_mdr <= bus.mem_rdata;
                if (bus.reg_write && f_wdst() != 0)
                    m_rf[f_wdst()] <= bus.mem_to_reg ? m_mdr : m_alo;
                if (f_pc_take()) m_pc <= f_pc_next();
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Compare process: every output against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("opcode",    64'(bus.opcode),    64'(m_ir[31:26]));
            chk("funct",     64'(bus.funct),     64'(m_ir[5:0]));
            chk("zero",      64'(bus.zero),      64'(f_alu() == '0));
            chk("mem_req",   64'(bus.mem_req),   64'(f_req()));
            chk("mem_wait",  64'(bus.mem_wait),  64'(f_wait()));
            chk("mem_we",    64'(bus.mem_we),    64'(bus.mem_write));
            chk("mem_addr",  64'(bus.mem_addr),  64'(bus.i_or_d ? m_alo : m_pc));
            chk("mem_wdata", 64'(bus.mem_wdata), 64'(m_b));
`ifdef MC_DP_PERF_EN
            chk("cycle_count",  64'(cycle_count),  64'(m_cyc));
            chk("retire_count", 64'(retire_count), 64'(m_ret));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        bus.mem_to_reg  = 0; bus.reg_dest  = 0; bus.i_or_d    = 0;
        bus.alu_src_a   = 0; bus.ir_write  = 0; bus.mem_read  = 0;
        bus.mem_write   = 0; bus.pc_write  = 0; bus.branch    = 0;
        bus.branch_ne   = 0; bus.reg_write = 0;
        bus.alu_src_b   = 2'd0; bus.pc_src = 2'd0; bus.alu_control = 3'd0;
        bus.mem_rdata   = '0;   bus.mem_ready = 1'b1;
    endtask

    task automatic to_post();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        @(negedge clk);
        to_post();
    endtask

    task automatic fetch(input logic [31:0] instr);
        idle();
        bus.ir_write  = 1;
        bus.mem_rdata = instr;
        cyc();
        idle();
    endtask

    // Put a value into register idx through MDR (rt field of a fetched word)
    task automatic load_reg(input logic [4:0] idx, input logic [W-1:0] val);
        fetch({6'd0, 5'd0, idx, 16'd0});
        bus.mem_read  = 1;
        bus.mem_rdata = val;
        cyc();
        idle();
        bus.reg_write  = 1;
        bus.mem_to_reg = 1;
        cyc();
        idle();
    endtask

    task automatic rand_in();
        bus.mem_to_reg  = 1'($urandom); bus.reg_dest  = 1'($urandom);
        bus.i_or_d      = 1'($urandom); bus.alu_src_a = 1'($urandom);
        bus.ir_write    = 1'($urandom); bus.mem_read  = 1'($urandom);
        bus.mem_write   = 1'($urandom); bus.pc_write  = 1'($urandom);
        bus.branch      = 1'($urandom); bus.branch_ne = 1'($urandom);
        bus.reg_write   = 1'($urandom);
        bus.alu_src_b   = 2'($urandom); bus.pc_src    = 2'($urandom);
        bus.alu_control = 3'($urandom);
        bus.mem_rdata   = W'($urandom);
        bus.mem_ready   = ($urandom_range(0, 3) != 0);
        rst_n           = ($urandom_range(0, 63) != 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle();
        rst_n = 0;
        to_post();
        chk_en = 1;
        bus.ir_write = 1;
        @(negedge clk);
        chk("rst_pc",      64'(bus.mem_addr), 64'h100);
        chk("rst_opcode",  64'(bus.opcode),   64'h0);
        chk("rst_req_low", 64'(bus.mem_req),  64'h0);
        to_post();

        // Fetch with an immediately ready memory
        rst_n = 1;
        idle();
        bus.ir_write = 1; bus.alu_src_b = 2'd1; bus.alu_control = 3'b010;
        bus.pc_write = 1; bus.pc_src = 2'd0; bus.mem_rdata = 32'h8C22_0010;
        cyc();
        idle();
        @(negedge clk);
        chk("fetch_pc",     64'(bus.mem_addr), 64'h104);
        chk("fetch_opcode", 64'(bus.opcode),   64'h23);
        chk("fetch_funct",  64'(bus.funct),    64'h10);
        to_post();

        // Same fetch with three wait cycles
        bus.ir_write = 1; bus.alu_src_b = 2'd1; bus.alu_control = 3'b010;
        bus.pc_write = 1; bus.pc_src = 2'd0; bus.mem_rdata = 32'h0000_002A;
        bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_wait",  64'(bus.mem_wait), 64'h1);
            chk("stall_pc",    64'(bus.mem_addr), 64'h104);
            chk("stall_ir",    64'(bus.opcode),   64'h23);
            to_post();
        end
        bus.mem_ready = 1;
        @(negedge clk);
        chk("stall_release", 64'(bus.mem_wait), 64'h0);
        to_post();
        idle();
        @(negedge clk);
        chk("stall_pc_done", 64'(bus.mem_addr), 64'h108);
        chk("stall_ir_done", 64'(bus.funct),    64'h2A);
        to_post();

        // branch_ne with equal and unequal operands
        for (int k = 0; k < 2; k++) begin
            load_reg(5'd1, 32'd5);
            load_reg(5'd2, (k == 0) ? 32'd5 : 32'd6);
            fetch({6'd0, 5'd1, 5'd2, 16'd0});
            bus.alu_src_b = 2'd1; bus.alu_control = 3'b010;   // ALUOut <= PC + 4
            cyc();
            idle();
            bus.alu_src_a = 1; bus.alu_control = 3'b110; bus.branch_ne = 1; bus.pc_src = 2'd1;
            @(negedge clk);
            chk("bne_zero", 64'(bus.zero), (k == 0) ? 64'h1 : 64'h0);
            to_post();
            idle();
            @(negedge clk);
            chk("bne_pc", 64'(bus.mem_addr), (k == 0) ? 64'h108 : 64'h10C);
            to_post();
        end

        // r0 discards writes; index 25 aliases r9 with 16 registers
        load_reg(5'd0, 32'hDEAD);
        load_reg(5'd9, 32'h1234);
        fetch({6'd0, 5'd25, 5'd0, 16'd0});
        cyc();
        @(negedge clk);
        chk("r0_read", 64'(bus.mem_wdata), 64'h0);
        to_post();
        fetch({6'd0, 5'd0, 5'd25, 16'd0});
        cyc();
        @(negedge clk);
        chk("r25_alias_r9", 64'(bus.mem_wdata), 64'h1234);
        to_post();

        // Register jump
        load_reg(5'd3, 32'h2000);
        fetch({6'd0, 5'd3, 5'd0, 16'd0});
        cyc();
        bus.pc_src = 2'd3; bus.pc_write = 1;
        cyc();
        idle();
        @(negedge clk);
        chk("jr_pc", 64'(bus.mem_addr), 64'h2000);
        to_post();

        // Signed set-less-than: -1 < 1
        load_reg(5'd4, 32'hFFFF_FFFF);
        load_reg(5'd5, 32'd1);
        fetch({6'd0, 5'd4, 5'd5, 16'd0});
        cyc();
        bus.alu_src_a = 1; bus.alu_control = 3'b111;
        @(negedge clk);
        chk("slt_zero", 64'(bus.zero), 64'h0);
        to_post();
        idle();
        bus.i_or_d = 1;
        @(negedge clk);
        chk("slt_result", 64'(bus.mem_addr), 64'h1);
        to_post();

        // Reset in the middle of a stall
        idle();
        bus.ir_write = 1; bus.mem_ready = 0; bus.mem_rdata = 32'hFFFF_FFFF;
        cyc();
        rst_n = 0;
        @(negedge clk);
        chk("rst_stall_req",  64'(bus.mem_req),  64'h0);
        chk("rst_stall_wait", 64'(bus.mem_wait), 64'h0);
        to_post();
        rst_n = 1;
        idle();
        @(negedge clk);
        chk("rst_stall_pc",    64'(bus.mem_addr),  64'h100);
        chk("rst_stall_b",     64'(bus.mem_wdata), 64'h0);
        chk("rst_stall_ir",    64'(bus.opcode),    64'h0);
`ifdef MC_DP_PERF_EN
        chk("rst_cycle_count",  64'(cycle_count),  64'h0);
        chk("rst_retire_count", 64'(retire_count), 64'h0);
`endif
        to_post();

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            rand_in();
            cyc();
        end
        rst_n = 1;
        idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mc_datapath_p.md
MC_DATAPATH_P -- requirements
Module: mc_datapath_p

Interface
REQ-001 Parameter WIDTH, default 32, data/address width; legal values 32 or 64.
REQ-002 Parameter NREGS, default 32, register file depth; legal values 16 or 32.
REQ-003 Parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 Control inputs, all 1 bit: mem_to_reg, reg_dest, i_or_d, alu_src_a, ir_write, mem_read, mem_write, pc_write, branch, branch_ne, reg_write.
REQ-007 alu_src_b  in  2, pc_src  in  2, alu_control  in  3  multi-bit controller selects.
REQ-008 opcode  out  6  IR[31:26]; funct  out  6  IR[5:0]; zero  out  1  ALU zero flag, combinational.
REQ-009 mem_req, mem_we  out  1; mem_addr, mem_wdata  out  WIDTH; mem_rdata  in  WIDTH; mem_ready  in  1  external memory handshake.
REQ-010 mem_wait  out  1  stall indication to controller.

Function
REQ-011 Registers: PC, IR (32 b), MDR, A, B, ALUOut; IR bits above 31 do not exist, and instruction data is mem_rdata[31:0].
REQ-012 mem_addr = i_or_d ? ALUOut : PC; mem_wdata = B; mem_we = mem_write.
REQ-013 mem_req = rst_n & (ir_write | mem_read | mem_write); mem_wait = mem_req & ~mem_ready.
REQ-014 A transfer completes on the edge where mem_req & mem_ready; the request is held stable while mem_wait is high, and no timeout applies.
REQ-015 While mem_wait is high, PC, IR, MDR, A, B, ALUOut and the register file hold their values.
REQ-016 IR loads mem_rdata[31:0] on the edge where ir_write & mem_ready; MDR loads mem_rdata on the edge where mem_read & mem_ready.
REQ-017 A, B and ALUOut load every non-stalled cycle from register file ports 1 and 2 and from the ALU result, respectively.
REQ-018 Register file: read addresses IR[25:21] and IR[20:16]; write address IR[15:11] if reg_dest, else IR[20:16]; all indices truncated to their low log2(NREGS) bits.
REQ-019 Write data is MDR if mem_to_reg, else ALUOut; the write occurs when reg_write & ~mem_wait.
REQ-020 Register 0 always reads 0, and writes to it are discarded; reads are asynchronous, and a same-cycle write is not forwarded.
REQ-021 srcA = alu_src_a ? A : PC; srcB is selected by alu_src_b: 00 B, 01 constant 4, 10 sext(IR[15:0]), 11 sext(IR[15:0])<<2, all extended to WIDTH.
REQ-022 alu_control: 010 add, 110 sub, 000 and, 001 or, 111 slt (signed, result 1/0); other codes give 0; arithmetic wraps modulo 2^WIDTH; zero = (result == 0).
REQ-023 Next PC is selected by pc_src: 00 ALU result, 01 ALUOut, 10 {PC[WIDTH-1:28], IR[25:0], 2'b00}, 11 A (register jump).
REQ-024 pc_en = ~mem_wait & (pc_write | (branch & zero) | (branch_ne & ~zero)); simultaneous branch and branch_ne is equivalent to unconditional pc_write.

Reset
REQ-025 When rst_n is low at a clock edge: PC <= RESET_PC; IR, MDR, A, B, ALUOut and all registers <= 0.
REQ-026 While rst_n is low, mem_req and mem_wait are 0, and a transfer in progress is abandoned without completing.
REQ-027 Reset overrides stall and every write enable.

Configuration
REQ-028 Macro MC_DP_PERF_EN: when defined, add outputs cycle_count (32 b) and retire_count (32 b).
REQ-029 cycle_count increments every non-reset cycle; retire_count increments on each completed IR load (REQ-016); both reset to 0 and wrap from 0xFFFFFFFF to 0.
REQ-030 When MC_DP_PERF_EN is undefined, neither port nor counter exists, and all other behaviour is identical.

Verification
REQ-031 Reset with RESET_PC=0x100, then release; fetch with ir_write=1, pc_src=00, alu_src_b=01 and mem_ready=1 -> IR=mem_rdata and PC=0x104 after one edge.
REQ-032 The same fetch with mem_ready low for 3 cycles -> mem_wait=1 for 3 cycles, PC stays 0x100 and IR is unchanged; the update occurs on the 4th edge.
REQ-033 A=5, B=5, alu_control=110, branch_ne=1, pc_src=01 -> zero=1 and PC holds; with B=6 -> PC<=ALUOut.
REQ-034 Write 0xDEAD to register 0 and 0x1234 to register 9 -> reading r0 gives 0 and r9 gives 0x1234; with NREGS=16, index 25 aliases register 9.
REQ-035 pc_src=11 with A=0x2000 and pc_write=1 -> PC=0x2000; slt with A=-1, B=1 -> ALU result 1.
REQ-036 Assert rst_n low mid-stall -> mem_req=0 in that cycle, and all state equals reset values after the edge; with MC_DP_PERF_EN defined, both counters equal 0.
